// File: rtl/rle_expander_if.sv
// ============================================================================
//  Module      : rle_expander_if
//  Description : Stream bundle for the RLE expander. Carries the run-length
//                input stream and the packed output word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rle_expander_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  localparam int c_ocnt_w = $clog2(DATA_W) + 1;

  // Input side: header word, then run lengths
  logic [CNT_W-1:0]    in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;

  // Output side: packed bits, LSB-first
  logic [DATA_W-1:0]   out_data;
  logic [c_ocnt_w-1:0] out_count;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  // Expander side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_valid, out_last
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_valid, out_last
  );
endinterface

`default_nettype wire

// File: rtl/rle_expander.sv
// ============================================================================
//  Module      : rle_expander
//  Description : Run-length decoder. A header word sets the initial bit value,
//                each following run length emits that many copies of the
//                current bit (alternating between runs), packed LSB-first into
//                DATA_W-bit words. The final partial word is zero-padded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rle_expander #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input wire            clk,
  input wire            rst,
  rle_expander_if.slave bus
);

  localparam int                  c_idx_w    = $clog2(DATA_W);
  localparam int                  c_ocnt_w   = $clog2(DATA_W) + 1;
  localparam logic [c_idx_w-1:0]  c_idx_max  = c_idx_w'(DATA_W - 1);
  localparam logic [c_ocnt_w-1:0] c_full_cnt = c_ocnt_w'(DATA_W);

  typedef enum logic [1:0] {
    S_HEADER   = 2'd0,
    S_RUN_WAIT = 2'd1,
    S_EXPAND   = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_cur_bit;
  logic [c_idx_w-1:0]  r_idx;
  logic [CNT_W-1:0]    r_rem;
  logic                r_last_r;
  logic [DATA_W-1:0]   r_acc;

  logic [DATA_W-1:0]   r_out_data;
  logic [c_ocnt_w-1:0] r_out_count;
  logic                r_out_valid;
  logic                r_out_last;

  logic                w_stall;
  logic                w_in_ready;
  logic                w_in_xfer;
  logic                w_run_zero;
  logic                w_write;
  logic                w_word_full;
  logic                w_run_end;
  logic                w_flush;
  logic [DATA_W-1:0]   w_acc_wr;

  // A registered word that downstream has not taken freezes all progress
  assign w_stall     = r_out_valid && !bus.out_ready;
  assign w_in_ready  = ((r_state == S_HEADER) || (r_state == S_RUN_WAIT)) && !w_stall;
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_run_zero  = (bus.in_data == '0);
  assign w_write     = (r_state == S_EXPAND) && !w_stall;
  assign w_word_full = (r_idx == c_idx_max);
  assign w_run_end   = (r_rem == CNT_W'(1));
  assign w_flush     = (r_state == S_FLUSH) && !w_stall;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;

  // Accumulator with the current bit dropped into the next free position
  always_comb begin
    w_acc_wr        = r_acc;
    w_acc_wr[r_idx] = r_cur_bit;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HEADER: begin
        if (w_in_xfer) w_state_nxt = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (w_in_xfer) begin
          if (!w_run_zero)      w_state_nxt = S_EXPAND;
          else if (bus.in_last) w_state_nxt = S_FLUSH;
        end
      end
      S_EXPAND: begin
        if (w_write && w_run_end) begin
          // A word completed by the final bit already carries out_last
          if (!r_last_r)        w_state_nxt = S_RUN_WAIT;
          else if (w_word_full) w_state_nxt = S_HEADER;
          else                  w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!w_stall) w_state_nxt = S_HEADER;
      end
      default: w_state_nxt = S_HEADER;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HEADER;
    else      r_state <= w_state_nxt;
  end

  // Run tracking, bit packing and output word register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_bit   <= 1'b0;
      r_idx       <= '0;
      r_rem       <= '0;
      r_last_r    <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      // Accepted word retires unless replaced below in the same cycle
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      if ((r_state == S_HEADER) && w_in_xfer) begin
        r_cur_bit <= bus.in_data[0];
        r_idx     <= '0;
        r_acc     <= '0;
      end

      if ((r_state == S_RUN_WAIT) && w_in_xfer) begin
        if (w_run_zero) begin
          r_cur_bit <= ~r_cur_bit;
        end else begin
          r_rem    <= bus.in_data;
          r_last_r <= bus.in_last;
        end
      end

      if (w_write) begin
        r_rem <= r_rem - CNT_W'(1);
        if (w_run_end) r_cur_bit <= ~r_cur_bit;
        if (w_word_full) begin
          r_out_data  <= w_acc_wr;
          r_out_count <= c_full_cnt;
          r_out_last  <= w_run_end && r_last_r;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_idx       <= '0;
        end else begin
          r_acc <= w_acc_wr;
          r_idx <= r_idx + c_idx_w'(1);
        end
      end

      if (w_flush) begin
        r_out_data  <= r_acc;
        r_out_count <= c_ocnt_w'(r_idx);
        r_out_last  <= 1'b1;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_idx       <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rle_expander.sv
// ============================================================================
//  Module      : tb_rle_expander
//  Description : Directed self-checking bench for rle_expander (16/16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rle_expander;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic        last;
    logic [4:0]  count;
    logic [15:0] data;
  } word_t;

  word_t q[$];

  rle_expander_if #(.DATA_W(16), .CNT_W(16)) bus ();

  rle_expander #(.DATA_W(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every accepted output word
  always @(posedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      q.push_back({bus.out_last, bus.out_count, bus.out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sits just after a negedge; returns just after a negedge
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_timeout", 32'(n < 300), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] d,
                             input logic [4:0] c, input logic l);
    int n;
    word_t w;
    n = 0;
    while (q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      chk({tag, "_word_timeout"}, 32'd0, 32'd1);
    end else begin
      w = q.pop_front();
      chk({tag, "_data"},  32'(w.data),  32'(d));
      chk({tag, "_count"}, 32'(w.count), 32'(c));
      chk({tag, "_last"},  32'(w.last),  32'(l));
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (10) @(negedge clk);
    chk({tag, "_no_extra_words"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst           = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Header 1, runs 3, 13(last): word fills on the final bit
    send(16'd1, 1'b0);
    send(16'd3, 1'b0);
    send(16'd13, 1'b1);
    expect_word("t1", 16'h0007, 5'd16, 1'b1);
    expect_idle("t1");

    // Header 0, runs 4, 4(last): partial word flushed
    send(16'd0, 1'b0);
    send(16'd4, 1'b0);
    send(16'd4, 1'b1);
    expect_word("t2", 16'h00F0, 5'd8, 1'b1);
    expect_idle("t2");

    // Header 1, run 40(last), free-flowing output
    send(16'd1, 1'b0);
    send(16'd40, 1'b1);
    expect_word("t3a", 16'hFFFF, 5'd16, 1'b0);
    expect_word("t3b", 16'hFFFF, 5'd16, 1'b0);
    expect_word("t3c", 16'h00FF, 5'd8, 1'b1);
    expect_idle("t3");

    // Same frame with downstream stalled for 5 cycles on the first word
    bus.out_ready = 1'b0;
    send(16'd1, 1'b0);
    send(16'd40, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_timeout", 32'(n < 300), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data",  32'(bus.out_data), 32'h0000FFFF);
      chk("t4_hold_in_rdy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("t4_hold_count", 32'(bus.out_count), 32'd16);
    bus.out_ready = 1'b1;
    expect_word("t4a", 16'hFFFF, 5'd16, 1'b0);
    expect_word("t4b", 16'hFFFF, 5'd16, 1'b0);
    expect_word("t4c", 16'h00FF, 5'd8, 1'b1);
    expect_idle("t4");

    // Zero-length runs
    send(16'd1, 1'b0);
    send(16'd0, 1'b0);
    send(16'd2, 1'b1);
    expect_word("t5", 16'h0000, 5'd2, 1'b1);
    send(16'd1, 1'b0);
    send(16'd0, 1'b1);
    expect_word("t6", 16'h0000, 5'd0, 1'b1);
    expect_idle("t6");

    // Reset in the middle of a long run
    bus.out_ready = 1'b0;
    send(16'd1, 1'b0);
    send(16'd40, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t7_valid_timeout", 32'(n < 300), 32'd1);
    rst = 1'b0;
    #1;
    chk("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t7_rst_out_data",  32'(bus.out_data),  32'd0);
    chk("t7_rst_out_count", 32'(bus.out_count), 32'd0);
    chk("t7_rst_out_last",  32'(bus.out_last),  32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t7_no_flush", 32'(q.size()), 32'd0);
    send(16'd0, 1'b0);
    send(16'd4, 1'b0);
    send(16'd4, 1'b1);
    expect_word("t7", 16'h00F0, 5'd8, 1'b1);
    expect_idle("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/rle_expander.md
RLE_EXPANDER -- requirements
Module: rle_expander

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output word width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 16, run-length field width in bits (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  CNT_W  header word (bit 0 = initial bit value) or run length.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  current run is the final run of the frame; ignored on header words.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  DATA_W  expanded bits, LSB-first; unused upper bits zero.
REQ-010 SHALL have port out_count  output  $clog2(DATA_W)+1  number of valid bits in out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_count/out_last valid.
REQ-012 SHALL have port out_last  output  1  word is the final word of the frame.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-014 SHALL implement states HEADER, RUN_WAIT, EXPAND and FLUSH.
REQ-015 SHALL transfer an input word only when in_valid && in_ready, and an output word only when out_valid && out_ready.
REQ-016 SHALL drive in_ready=1 only in HEADER and RUN_WAIT, and only while !(out_valid && !out_ready).
REQ-017 SHALL, on a HEADER transfer, load cur_bit<=in_data[0], clear bit index idx, and go to RUN_WAIT.
REQ-018 SHALL, on a RUN_WAIT transfer with in_data!=0, load rem<=in_data and last_r<=in_last, then go to EXPAND.
REQ-019 SHALL, on a RUN_WAIT transfer with in_data==0, invert cur_bit, then go to FLUSH if in_last, else stay in RUN_WAIT.
REQ-020 SHALL, in EXPAND, write one bit (cur_bit at position idx) per cycle, but only while !(out_valid && !out_ready); otherwise hold all state.
REQ-021 SHALL write the first bit of a run the cycle after that run's transfer.
REQ-022 SHALL decrement rem and increment idx on each written bit, with arithmetic on CNT_W bits (maximum run 2^CNT_W-1).
REQ-023 SHALL, when the written bit fills position DATA_W-1, register the full word next cycle with out_valid=1, out_count=DATA_W, and idx<=0.
REQ-024 SHALL, when the written bit is the run's last (rem==1), invert cur_bit, then go to FLUSH if last_r, else RUN_WAIT.
REQ-025 SHALL, when a word fills on the last bit of the last run, set out_last=1 on that word and go directly to HEADER, bypassing FLUSH.
REQ-026 SHALL, in FLUSH (entered only when not stalled), emit the partial word zero-padded with out_count=idx and out_last=1, then go to HEADER.
REQ-027 SHALL, for a frame with zero total bits (FLUSH with idx==0 and no bits written), emit out_data=0, out_count=0, out_last=1.
REQ-028 SHALL hold out_data/out_count/out_last stable while out_valid && !out_ready, and clear out_valid on acceptance unless a new word is registered the same cycle.

Reset
REQ-029 SHALL, while rst=0, asynchronously force state=HEADER, out_valid=0, out_last=0, out_data=0, out_count=0, idx=0, rem=0, cur_bit=0.
REQ-030 SHALL drive in_ready=1 on the first cycle after rst deasserts (no output pending).
REQ-031 SHALL discard a partially expanded frame on reset mid-operation, emitting no flush word.

Verification (DATA_W=16, CNT_W=16)
REQ-032 SHALL verify: header 1, runs 3 and 13(last) -> one word 0x0007, count 16, out_last=1.
REQ-033 SHALL verify: header 0, runs 4 and 4(last) -> one word 0x00F0, count 8, out_last=1.
REQ-034 SHALL verify: header 1, run 40(last), out_ready=1 -> 0xFFFF/16, 0xFFFF/16, then 0x00FF/8 with out_last=1.
REQ-035 SHALL verify: same as REQ-034 with out_ready=0 for 5 cycles while the first word is valid -> out_data held at 0xFFFF, in_ready=0, same three words delivered, no bits lost.
REQ-036 SHALL verify zero-length runs: header 1, runs 0 and 2(last) -> 0x0000, count 2, last; and header 1, run 0(last) -> 0x0000, count 0, last.
REQ-037 SHALL verify: rst=0 asserted mid-EXPAND of a 40-bit run -> outputs zero immediately; after release in_ready=1, state=HEADER, and the next frame decodes correctly.
